latch_stage: RTL
================

Name: latch_stage

Overview:
- Generic parametrised pipeline-stage register; successor to the fixed per-stage latches between IF/ID/EX/MEM/WB.
- Carries an opaque WIDTH-bit payload, e.g. a packed operator/category/operands/write-enable/write-address bundle.
- Adds valid/ready handshaking, a 2-entry skid buffer so upstream ready is registered, and synchronous flush with bubble insertion.
- Instantiated once per stage boundary in the CPU pipeline.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- NOP_VALUE, {WIDTH{1'b0}}, payload driven while the stage holds a bubble.
- STAT_WIDTH, 16, width of statistic counters; used only with the optional feature.

Ports:
- clock  input  1  stage clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-low: reset==0 at a rising edge resets the block.
- flush  input  1  synchronous flush; discards all held and incoming entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  registered; block can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  registered; out_data holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  registered payload; equals NOP_VALUE when out_valid==0.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data/out_valid) and skid register.
- States:
  - EMPTY: no valid entry.
  - ONE: main valid.
  - TWO: main and skid valid.
- in_ready is 1 in EMPTY and ONE, 0 in TWO. It is a registered function of next state, with no combinational path from out_ready.
- Reset (reset==0, highest priority):
  - Next state EMPTY; out_valid=0, out_data=NOP_VALUE, skid=NOP_VALUE, in_ready=1.
  - Inputs are ignored that cycle.
  - Reset mid-operation drops all held entries with no drain.
- Flush (reset==1, flush==1, second priority):
  - Next state EMPTY; out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - An in_fire in the same cycle is consumed and discarded.
  - An out_fire in the same cycle still counts as delivered downstream.
- Transitions when reset==1 and flush==0:
  - EMPTY, in_fire → main=in_data, ONE.
  - EMPTY, no in_fire → stay EMPTY.
  - ONE, in_fire & out_fire → main=in_data, stay ONE. Full throughput: one payload per cycle.
  - ONE, in_fire only → skid=in_data, TWO.
  - ONE, out_fire only → main=NOP_VALUE, EMPTY.
  - ONE, neither → hold.
  - TWO, out_fire → main=skid, skid=NOP_VALUE, ONE.
  - TWO, no out_fire → hold.
  - in_fire is impossible in TWO because in_ready==0.
- Ordering: payloads leave in acceptance order; none is duplicated or lost except on flush/reset.
- Latency: a payload accepted in EMPTY appears on out_data the next cycle. Minimum latency is 1 cycle, identical to the prior fixed latches.
- out_data is stable while out_valid==1 and out_ready==0.
- in_data is sampled only on in_fire; its value is ignored otherwise.
- in_valid is asserted only by upstream and does not depend on in_ready. Upstream holds in_valid/in_data until in_fire.

Optional Feature:
- Macro: LATCH_STAGE_STATS_EN.
- When defined, two output ports are added, each STAT_WIDTH wide:
  - stall_count: increments each cycle out_valid==1 & out_ready==0.
  - flush_count: increments each cycle flush==1 & reset==1.
- Both counters:
  - Saturate at all-ones; no wrap.
  - Reset to 0 on reset==0; flush does not clear them.
  - Update on the same edge as the event.
- When undefined: no ports, no counter logic, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1, in_data=0xDEAD → out_valid=0, out_data=NOP_VALUE, in_ready=1 after release. No payload is captured.
- Streaming: out_ready=1, push 0x1,0x2,0x3,0x4 on consecutive cycles → out_data shows 0x1..0x4 on consecutive cycles starting 1 cycle after the first push; in_ready stays 1.
- Backpressure/skid: out_ready=0, push 0xA then 0xB → in_ready=0 after the second push, state TWO. Raise out_ready → 0xA then 0xB delivered; in_ready returns to 1 one cycle after 0xA leaves.
- Flush in TWO: hold 0xA,0xB, assert flush with in_valid=1, in_data=0xC → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1. 0xC is never delivered.
- Reset mid-stream: during streaming of 0x10..0x13, drive reset=0 for one cycle → all outputs at reset values next cycle. The stream restarts cleanly with the next push.
- Stats (LATCH_STAGE_STATS_EN, STAT_WIDTH=4): stall 20 cycles with out_valid=1 → stall_count=15 (saturated). Two flushes → flush_count=2. reset=0 → both 0.

Source files
------------

// File: rtl/latch_stage.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer and flush.
// Define LATCH_STAGE_STATS_EN to add saturating stall_count/flush_count outputs.
module latch_stage #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE  = {WIDTH{1'b0}},
   parameter int               STAT_WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       o_dbg_state
`ifdef LATCH_STAGE_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] stall_count,
   output logic [STAT_WIDTH-1:0] flush_count
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; ready never depends on valid, and in_ready is a pure register.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_next_main;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_next_skid;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_comb begin
      w_next_state = r_state;
      w_next_main  = r_main;
      w_next_skid  = r_skid;
      if (flush) begin
         // Any same-cycle in_fire is swallowed here on purpose.
         w_next_state = ST_EMPTY;
         w_next_main  = NOP_VALUE;
         w_next_skid  = NOP_VALUE;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_next_main  = in_data;
                  w_next_state = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_next_main = in_data;
               end else if (w_in_fire) begin
                  w_next_skid  = in_data;
                  w_next_state = ST_TWO;
               end else if (w_out_fire) begin
                  w_next_main  = NOP_VALUE;
                  w_next_state = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  w_next_main  = r_skid;
                  w_next_skid  = NOP_VALUE;
                  w_next_state = ST_ONE;
               end
            end
            default: begin
               w_next_state = ST_EMPTY;
               w_next_main  = NOP_VALUE;
               w_next_skid  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_main      <= NOP_VALUE;
         r_skid      <= NOP_VALUE;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_next_state;
         r_main      <= w_next_main;
         r_skid      <= w_next_skid;
         r_out_valid <= (w_next_state != ST_EMPTY);
         r_in_ready  <= (w_next_state != ST_TWO);
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_main;
   assign o_dbg_state = r_state;

`ifdef LATCH_STAGE_STATS_EN
   logic [STAT_WIDTH-1:0] r_stall_count;
   logic [STAT_WIDTH-1:0] r_flush_count;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (r_out_valid && !out_ready && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + STAT_WIDTH'(1);
         end
         if (flush && !(&r_flush_count)) begin
            r_flush_count <= r_flush_count + STAT_WIDTH'(1);
         end
      end
   end

   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;
`endif

endmodule
